// File: rtl/mult_sequencer_pkg.sv
// rtl/mult_sequencer_pkg.sv - shared types and defaults for the HI/LO multiply sequencer
// Contents:
//   mult_state_t       sequencer states IDLE -> ACCUM -> FIX -> DONE
//   MULT_WIDTH         default operand width (product is twice this)
//   MULT_PP_PER_CYCLE  default partial-product rows summed per ACCUM cycle
//   MULT_STEPS         ACCUM cycles per multiply
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH        = 32;
  localparam int MULT_PP_PER_CYCLE = 4;
  localparam int MULT_STEPS        = MULT_WIDTH / MULT_PP_PER_CYCLE;

endpackage

// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - request/result bundle between EX stage and multiply sequencer
// Signals:
//   start, is_signed, a, b, flush   requester -> sequencer
//   busy, done, hi, lo              sequencer -> requester
// Modports:
//   master  requester side (EX stage / exception logic)
//   slave   sequencer side
interface mult_sequencer_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_sequencer_pp_row_adder.sv
// rtl/mult_sequencer_pp_row_adder.sv - sums one cycle's worth of shifted partial-product rows
// Ports:
//   a_mag_i       in   WIDTH          multiplicand magnitude
//   b_bits_i      in   PP_PER_CYCLE   multiplier bits for this cycle (LSB = row at shift_base_i)
//   shift_base_i  in   log2(2*WIDTH)  bit position of the first row
//   sum_o         out  2*WIDTH        sum of the PP_PER_CYCLE shifted rows
module pp_row_adder
  import mult_pkg::*;
#(
  parameter int WIDTH        = MULT_WIDTH,
  parameter int PP_PER_CYCLE = MULT_PP_PER_CYCLE
) (
  input  logic [WIDTH-1:0]             a_mag_i,
  input  logic [PP_PER_CYCLE-1:0]      b_bits_i,
  input  logic [$clog2(2*WIDTH)-1:0]   shift_base_i,
  output logic [2*WIDTH-1:0]           sum_o
);

  always_comb begin
    logic [2*WIDTH-1:0] partial;
    partial = '0;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      partial = partial +
                ({{WIDTH{1'b0}}, a_mag_i & {WIDTH{b_bits_i[k]}}} << (shift_base_i + k));
    end
    sum_o = partial;
  end

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - multi-cycle controller for the HI/LO multiply unit (MULT/MULTU)
// Ports:
//   clk_i   in   1  clock, rising edge
//   rst_i   in   1  synchronous active-high reset
//   bus     slave modport of mult_sequencer_if:
//             start/is_signed/a/b  request, sampled in IDLE or DONE
//             flush                abort in-flight multiply, blocks accept
//             busy                 high in ACCUM or FIX (MFHI/MFLO interlock)
//             done                 one-cycle pulse, hi/lo valid in the same cycle
//             hi/lo                upper/lower half of the product
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH        = MULT_WIDTH,
  parameter int PP_PER_CYCLE = MULT_PP_PER_CYCLE
) (
  input logic              clk_i,
  input logic              rst_i,
  mult_sequencer_if.slave  bus
);

  localparam int STEPS = WIDTH / PP_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SH_W  = $clog2(2 * WIDTH);

  mult_state_t          state_q, state_d;
  logic [WIDTH-1:0]     a_mag_q, a_mag_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                    accept;
  logic [WIDTH-1:0]        a_abs, b_abs;
  logic [PP_PER_CYCLE-1:0] b_slice;
  logic [SH_W-1:0]         shift_base;
  logic [2*WIDTH-1:0]      row_sum;
  logic [2*WIDTH-1:0]      result;

  // Signed operands are reduced to magnitudes so the array is purely unsigned;
  // the most negative value maps to itself, which is its correct unsigned magnitude.
  assign a_abs = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign b_slice    = b_mag_q[cnt_q*PP_PER_CYCLE +: PP_PER_CYCLE];
  assign shift_base = SH_W'(cnt_q * PP_PER_CYCLE);
  assign result     = neg_q ? -acc_q : acc_q;

  pp_row_adder #(
    .WIDTH        (WIDTH),
    .PP_PER_CYCLE (PP_PER_CYCLE)
  ) u_pp_row_adder (
    .a_mag_i      (a_mag_q),
    .b_bits_i     (b_slice),
    .shift_base_i (shift_base),
    .sum_o        (row_sum)
  );

  // A new request is only taken while idle or in the single DONE cycle, and
  // never in a cycle where exception logic is flushing.
  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.flush;

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + row_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == ACCUM) || (state_q == FIX);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(
    .WIDTH        (32),
    .PP_PER_CYCLE (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Full-width product by plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0, then watch 13 cycles: done expected only in cycle 10.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp);
    int          busy_n, done_n, done_at;
    logic [63:0] got;
    bus.a = a; bus.b = b; bus.is_signed = s; bus.start = 1'b1;
    busy_n = 0; done_n = 0; done_at = -1; got = '0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          got = {bus.hi, bus.lo};
        end
      end
    end
    chk({tag, " done_cycle"}, 64'(done_at), 64'd10);
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'd9);
    chk({tag, " done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, " product"}, got, exp);
  endtask

  initial begin : stim
    logic [31:0] ra, rb;
    logic        rs;
    int          done_n, first_at, second_at;
    logic [63:0] got1, got2;

    rst = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    tick();
    tick();
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    tick();

    run_op("t1 multu", 32'h8888_8888, 32'hFFFF_FFFF, 1'b0, 64'h8888_8887_7777_7778);

    // Flush during ACCUM: no done, result registers untouched.
    bus.a = 32'd2; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
    done_n = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.start = 1'b0;
      bus.flush = (c == 4);
      if (c == 5) chk("t4 busy_after_flush", 64'(bus.busy), 64'd0);
      if (bus.done) done_n++;
    end
    bus.flush = 1'b0;
    chk("t4 no_done", 64'(done_n), 64'd0);
    chk("t4 hilo_kept", {bus.hi, bus.lo}, 64'h8888_8887_7777_7778);

    run_op("t2 mult", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("t2 multu", 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1);
    run_op("t3 min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op("t3 max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);

    // Start held high: single done at 10, re-start in DONE with new operands.
    bus.a = 32'd2; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
    done_n = 0; first_at = -1; second_at = -1; got1 = '0; got2 = '0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 11) bus.start = 1'b0;
      if (bus.done) begin
        done_n++;
        if (first_at < 0) begin
          first_at = c;
          got1 = {bus.hi, bus.lo};
          bus.a = 32'd7; bus.b = 32'd7;
        end else if (second_at < 0) begin
          second_at = c;
          got2 = {bus.hi, bus.lo};
        end
      end
    end
    bus.start = 1'b0;
    chk("t5 done_pulses", 64'(done_n), 64'd2);
    chk("t5 first_done", 64'(first_at), 64'd10);
    chk("t5 first_product", got1, 64'd6);
    chk("t5 second_done", 64'(second_at), 64'd20);
    chk("t5 second_product", got2, 64'h31);

    // Reset in the middle of a multiply.
    bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom_range(0, 1));
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    chk("t6 busy", 64'(bus.busy), 64'd0);
    chk("t6 done", 64'(bus.done), 64'd0);
    chk("t6 hi", 64'(bus.hi), 64'd0);
    chk("t6 lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    ra = $urandom; rb = $urandom; rs = 1'b1;
    run_op("t6 after_reset", ra, rb, rs, ref_prod(ra, rb, rs));

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'hFFFF_FFFF;
      if (i == 2) ra = 32'd0;
      run_op($sformatf("rand%0d", i), ra, rb, rs, ref_prod(ra, rb, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
